// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and RAM-side strobe bundle for mem_arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [ADDR_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic              dwait;
    logic [ADDR_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    logic [1:0]        ramstate;

    // Arbiter side: consumes cache requests and RAM status, drives the rest.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Environment side: the two caches plus the RAM.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache has priority, icache gets the port after
// DBURST_MAX back-to-back dcache words. Optional transfer/stall counters are
// compiled in with `define MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int unsigned DBURST_MAX = 2,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]  dxfer_cnt,
    output logic [31:0]  ixfer_cnt,
    output logic [31:0]  stall_cnt
`endif
);
    localparam int unsigned CNT_W     = 2;
    localparam logic [1:0]  RS_ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] dcnt;

    logic dreq;
    logic access;
    logic d_done;
    logic i_done;
    logic burst_full;

    logic              ren_c;
    logic              wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] store_c;
    logic              iwait_c;
    logic              dwait_c;
    logic [ADDR_W-1:0] iload_c;
    logic [ADDR_W-1:0] dload_c;

    assign dreq       = bus.dREN | bus.dWEN;
    assign access     = (bus.ramstate == RS_ACCESS);
    assign d_done     = (state == SERVE_D) && dreq && access;
    assign i_done     = (state == SERVE_I) && bus.iREN && access;
    assign burst_full = (32'(dcnt) + 32'd1) >= 32'(DBURST_MAX);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: dropped request abandons, completion re-arbitrates, else hold.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dreq) begin
                    state_next = SERVE_D;
                end else if (bus.iREN) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_D: begin
                if (!dreq) begin
                    state_next = IDLE;
                end else if (access && bus.iREN && burst_full) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                if (!bus.iREN) begin
                    state_next = IDLE;
                end else if (access && dreq) begin
                    state_next = SERVE_D;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: route the granted requester to RAM, release wait on ACCESS.
    always_comb begin
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        store_c = '0;
        iwait_c = 1'b1;
        dwait_c = 1'b1;
        iload_c = '0;
        dload_c = '0;
        case (state)
            SERVE_D: begin
                wen_c   = bus.dWEN;
                ren_c   = bus.dREN & ~bus.dWEN;
                addr_c  = bus.daddr;
                store_c = bus.dstore;
                if (d_done) begin
                    dwait_c = 1'b0;
                    dload_c = bus.ramload;
                end
            end
            SERVE_I: begin
                ren_c  = bus.iREN;
                addr_c = bus.iaddr;
                if (i_done) begin
                    iwait_c = 1'b0;
                    iload_c = bus.ramload;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.ramREN   = ren_c;
    assign bus.ramWEN   = wen_c;
    assign bus.ramaddr  = addr_c;
    assign bus.ramstore = store_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = iload_c;
    assign bus.dload    = dload_c;

    // Burst counter: counts dcache words, cleared whenever dcache loses the grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dcnt <= '0;
        end else if (state_next != SERVE_D) begin
            dcnt <= '0;
        end else if (d_done && (32'(dcnt) < 32'(DBURST_MAX)) && (dcnt != CNT_MAX)) begin
            dcnt <= dcnt + CNT_W'(1);
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Completed-transfer and icache stall counters, wrapping modulo 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dxfer_cnt <= '0;
            ixfer_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (d_done) begin
                dxfer_cnt <= dxfer_cnt + 32'd1;
            end
            if (i_done) begin
                ixfer_cnt <= ixfer_cnt + 32'd1;
            end
            if ((state == SERVE_D) && bus.iREN) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, random traffic against a
// grant-ownership reference model, and counter checks when stats are built in.
module tb_mem_arbiter;
    localparam int unsigned DMAX = 2;
    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    typedef struct packed {
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  rs;
    } in_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        iwait;
        logic        dwait;
        logic [31:0] iload;
        logic [31:0] dload;
    } out_t;

    typedef struct {
        in_t  in;
        out_t ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] dxfer_cnt;
    logic [31:0] ixfer_cnt;
    logic [31:0] stall_cnt;
    int unsigned m_dx;
    int unsigned m_ix;
    int unsigned m_st;
`endif

    mem_arbiter #(.DBURST_MAX(DMAX), .ADDR_W(32)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .dxfer_cnt(dxfer_cnt),
        .ixfer_cnt(ixfer_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    int total;
    int bad;

    // Reference: who owns the RAM port, and how many dcache words it has taken.
    int  owner;   // 0 nobody, 1 dcache, 2 icache
    int  dwords;
    in_t cur;
    bit  last_d_done;
    bit  last_i_done;

    function automatic in_t mk_in(input logic r, input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic dw, input logic [31:0] da,
                                  input logic [31:0] ds, input logic [31:0] rl,
                                  input logic [1:0] rs);
        in_t x;
        x.rst = r; x.iren = ir; x.iaddr = ia; x.dren = dr; x.dwen = dw;
        x.daddr = da; x.dstore = ds; x.ramload = rl; x.rs = rs;
        return x;
    endfunction

    function automatic out_t mk_out(input logic ren, input logic wen, input logic [31:0] a,
                                    input logic [31:0] s, input logic iw, input logic dw,
                                    input logic [31:0] il, input logic [31:0] dl);
        out_t o;
        o.ren = ren; o.wen = wen; o.addr = a; o.store = s;
        o.iwait = iw; o.dwait = dw; o.iload = il; o.dload = dl;
        return o;
    endfunction

    function automatic void model_expect(input in_t x, output out_t e, output bit dd, output bit id);
        bit dreq;
        bit acc;
        dreq = x.dren | x.dwen;
        acc  = (x.rs == ACC);
        e = '0;
        e.iwait = 1'b1;
        e.dwait = 1'b1;
        dd = 1'b0;
        id = 1'b0;
        if (owner == 1) begin
            e.wen   = x.dwen;
            e.ren   = x.dren && !x.dwen;
            e.addr  = x.daddr;
            e.store = x.dstore;
            dd = dreq && acc;
            if (dd) begin
                e.dwait = 1'b0;
                e.dload = x.ramload;
            end
        end else if (owner == 2) begin
            e.ren  = x.iren;
            e.addr = x.iaddr;
            id = x.iren && acc;
            if (id) begin
                e.iwait = 1'b0;
                e.iload = x.ramload;
            end
        end
    endfunction

    task automatic model_step(input in_t x, input bit dd, input bit id);
        bit dreq;
        dreq = x.dren | x.dwen;
        if (x.rst) begin
            owner  = 0;
            dwords = 0;
`ifdef MEM_ARB_STATS_EN
            m_dx = 0; m_ix = 0; m_st = 0;
`endif
            return;
        end
`ifdef MEM_ARB_STATS_EN
        if (dd) m_dx++;
        if (id) m_ix++;
        if (owner == 1 && x.iren) m_st++;
`endif
        case (owner)
            0: owner = dreq ? 1 : (x.iren ? 2 : 0);
            1: begin
                if (!dreq) begin
                    owner = 0;
                end else if (dd) begin
                    dwords = (dwords + 1 > int'(DMAX)) ? int'(DMAX) : dwords + 1;
                    if (x.iren && dwords >= int'(DMAX)) owner = 2;
                end
            end
            default: begin
                if (!x.iren) owner = 0;
                else if (id && dreq) owner = 1;
            end
        endcase
        if (owner != 1) dwords = 0;
    endtask

    function automatic out_t sample();
        out_t o;
        o.ren = bus.ramREN; o.wen = bus.ramWEN; o.addr = bus.ramaddr; o.store = bus.ramstore;
        o.iwait = bus.iwait; o.dwait = bus.dwait; o.iload = bus.iload; o.dload = bus.dload;
        return o;
    endfunction

    task automatic compare(input string name, input out_t ex);
        out_t act;
        act = sample();
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h | want ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h",
                     name, act.ren, act.wen, act.addr, act.store, act.iwait, act.dwait, act.iload, act.dload,
                     ex.ren, ex.wen, ex.addr, ex.store, ex.iwait, ex.dwait, ex.iload, ex.dload);
        end
    endtask

    task automatic drive(input in_t x);
        cur           = x;
        rst           = x.rst;
        bus.iREN      = x.iren;
        bus.iaddr     = x.iaddr;
        bus.dREN      = x.dren;
        bus.dWEN      = x.dwen;
        bus.daddr     = x.daddr;
        bus.dstore    = x.dstore;
        bus.ramload   = x.ramload;
        bus.ramstate  = x.rs;
    endtask

    // One clock: drive, compare at negedge (table value or model), advance model.
    task automatic run_cycle(input in_t x, input bit use_tbl, input out_t tex, input string name);
        out_t mex;
        bit   dd;
        bit   id;
        drive(x);
        model_expect(x, mex, dd, id);
        @(negedge clk);
        if (use_tbl) compare(name, tex);
        else         compare(name, mex);
        @(posedge clk);
        model_step(x, dd, id);
        #1;
        last_d_done = dd;
        last_i_done = id;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, ex);
        end
    endtask

    vec_t tbl[$];
    out_t idle_o;

    initial begin
        bit          d_act;
        bit          d_wr;
        bit          d_both;
        logic [31:0] d_addr;
        logic [31:0] d_data;
        bit          i_act;
        logic [31:0] i_addr;
        in_t         x;
        out_t        none;

        total = 0; bad = 0; owner = 0; dwords = 0;
        last_d_done = 1'b0; last_i_done = 1'b0;
        none = '0;
        idle_o = mk_out(0, 0, 0, 0, 1, 1, 0, 0);
`ifdef MEM_ARB_STATS_EN
        m_dx = 0; m_ix = 0; m_st = 0;
`endif

        // Reset state
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        // Single dcache read, ACCESS on second grant cycle
        tbl.push_back('{mk_in(0,0,0,1,0,32'h40,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,0,0,1,0,32'h40,0,0,BUSY), mk_out(1,0,32'h40,0,1,1,0,0)});
        tbl.push_back('{mk_in(0,0,0,1,0,32'h40,0,32'hDEADBEEF,ACC), mk_out(1,0,32'h40,0,1,0,0,32'hDEADBEEF)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        // Simultaneous requests: dcache first, icache after dcache drops
        tbl.push_back('{mk_in(0,1,32'h200,1,0,32'h300,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,1,32'h200,1,0,32'h300,0,32'h11,ACC), mk_out(1,0,32'h300,0,1,0,0,32'h11)});
        tbl.push_back('{mk_in(0,1,32'h200,0,0,32'h300,0,0,FREE), mk_out(0,0,32'h300,0,1,1,0,0)});
        tbl.push_back('{mk_in(0,1,32'h200,0,0,0,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,1,32'h200,0,0,0,0,32'h22,ACC), mk_out(1,0,32'h200,0,0,1,32'h22,0)});
        tbl.push_back('{mk_in(0,0,32'h200,0,0,0,0,0,FREE), mk_out(0,0,32'h200,0,1,1,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        // Burst limit: 0x80, 0x84, then icache word, then 0x88
        tbl.push_back('{mk_in(0,1,32'h500,1,0,32'h80,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,1,32'h500,1,0,32'h80,0,32'hA0,ACC), mk_out(1,0,32'h80,0,1,0,0,32'hA0)});
        tbl.push_back('{mk_in(0,1,32'h500,1,0,32'h84,0,32'hA4,ACC), mk_out(1,0,32'h84,0,1,0,0,32'hA4)});
        tbl.push_back('{mk_in(0,1,32'h500,1,0,32'h88,0,32'hB0,ACC), mk_out(1,0,32'h500,0,0,1,32'hB0,0)});
        tbl.push_back('{mk_in(0,0,0,1,0,32'h88,0,32'hA8,ACC), mk_out(1,0,32'h88,0,1,0,0,32'hA8)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        // Write with two ERROR retries; dREN+dWEN together resolves to write
        tbl.push_back('{mk_in(0,0,0,0,1,32'h100,32'h12345678,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,0,0,0,1,32'h100,32'h12345678,32'h55,ERR), mk_out(0,1,32'h100,32'h12345678,1,1,0,0)});
        tbl.push_back('{mk_in(0,0,0,1,1,32'h100,32'h12345678,32'h55,ERR), mk_out(0,1,32'h100,32'h12345678,1,1,0,0)});
        tbl.push_back('{mk_in(0,0,0,1,1,32'h100,32'h12345678,32'h66,ACC), mk_out(0,1,32'h100,32'h12345678,1,0,0,32'h66)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        // Reset pulse during a BUSY icache access
        tbl.push_back('{mk_in(0,1,32'h700,0,0,0,0,0,FREE), idle_o});
        tbl.push_back('{mk_in(0,1,32'h700,0,0,0,0,0,BUSY), mk_out(1,0,32'h700,0,1,1,0,0)});
        tbl.push_back('{mk_in(1,1,32'h700,0,0,0,0,0,BUSY), mk_out(1,0,32'h700,0,1,1,0,0)});
        tbl.push_back('{mk_in(0,1,32'h700,0,0,0,0,0,BUSY), idle_o});
        tbl.push_back('{mk_in(0,1,32'h700,0,0,0,0,0,FREE), mk_out(1,0,32'h700,0,1,1,0,0)});
        tbl.push_back('{mk_in(0,1,32'h700,0,0,0,0,32'h77,ACC), mk_out(1,0,32'h700,0,0,1,32'h77,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,FREE), idle_o});
        // ACCESS seen with nobody granted must not leak data
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,32'h99,ACC), idle_o});

        drive(mk_in(1,0,0,0,0,0,0,0,FREE));
        repeat (2) begin
            @(posedge clk);
            model_step(cur, 1'b0, 1'b0);
        end
        #1;

        foreach (tbl[k]) begin
            run_cycle(tbl[k].in, 1'b1, tbl[k].ex, $sformatf("tbl%0d", k));
        end

        // Random traffic from two well-behaved caches plus occasional aborts and resets
        d_act = 1'b0; d_wr = 1'b0; d_both = 1'b0; d_addr = '0; d_data = '0;
        i_act = 1'b0; i_addr = '0;
        for (int n = 0; n < 3000; n++) begin
            if (d_act && (last_d_done || $urandom_range(0, 15) == 0)) d_act = 1'b0;
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act  = 1'b1;
                d_wr   = 1'($urandom_range(0, 1));
                d_both = ($urandom_range(0, 7) == 0);
                d_addr = 32'($urandom_range(0, 1023)) << 2;
                d_data = $urandom;
            end
            if (i_act && (last_i_done || $urandom_range(0, 15) == 0)) i_act = 1'b0;
            if (!i_act && $urandom_range(0, 1) == 0) begin
                i_act  = 1'b1;
                i_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            x = mk_in(($urandom_range(0, 149) == 0), i_act, i_addr,
                      d_act && (!d_wr || d_both), d_act && d_wr, d_addr, d_data,
                      $urandom, 2'($urandom_range(0, 3)));
            run_cycle(x, 1'b0, none, "rand");
        end

`ifdef MEM_ARB_STATS_EN
        check_val("rand_dxfer", dxfer_cnt, m_dx);
        check_val("rand_ixfer", ixfer_cnt, m_ix);
        check_val("rand_stall", stall_cnt, m_st);

        // Three dcache and two icache completions from a clean reset
        run_cycle(mk_in(1,0,0,0,0,0,0,0,FREE), 1'b1, sample(), "st_rst");
        run_cycle(mk_in(0,0,0,1,0,32'h10,0,0,FREE), 1'b0, none, "st0");
        run_cycle(mk_in(0,0,0,1,0,32'h10,0,32'h1,ACC), 1'b0, none, "st1");
        run_cycle(mk_in(0,0,0,1,0,32'h14,0,32'h2,ACC), 1'b0, none, "st2");
        run_cycle(mk_in(0,0,0,1,0,32'h18,0,32'h3,ACC), 1'b0, none, "st3");
        run_cycle(mk_in(0,1,32'h20,0,0,0,0,0,FREE), 1'b0, none, "st4");
        run_cycle(mk_in(0,1,32'h20,0,0,0,0,0,FREE), 1'b0, none, "st5");
        run_cycle(mk_in(0,1,32'h20,0,0,0,0,32'h4,ACC), 1'b0, none, "st6");
        run_cycle(mk_in(0,1,32'h24,0,0,0,0,32'h5,ACC), 1'b0, none, "st7");
        run_cycle(mk_in(0,0,0,0,0,0,0,0,FREE), 1'b0, none, "st8");
        check_val("dxfer_cnt", dxfer_cnt, 32'd3);
        check_val("ixfer_cnt", ixfer_cnt, 32'd2);
        check_val("stall_cnt", stall_cnt, 32'd1);
        run_cycle(mk_in(1,0,0,0,0,0,0,0,FREE), 1'b0, none, "st9");
        check_val("dxfer_rst", dxfer_cnt, 32'd0);
        check_val("ixfer_rst", ixfer_cnt, 32'd0);
        check_val("stall_rst", stall_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches of one CPU.
- Arbitrates their single-word requests onto one RAM port: drives RAM strobes, address and store data, and returns load data plus per-requester wait.
- Data cache has priority. Two-word block transfers (writeback or fetch) stay atomic, up to a burst limit.

Parameters:
- DBURST_MAX, 2, maximum consecutive data-cache word transactions granted while the icache is waiting.
- ADDR_W, 32, address and data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache wait; 0 = access completes this cycle.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache wait; 0 = access completes this cycle.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- States: IDLE, SERVE_D, SERVE_I. State is registered; RST forces IDLE, burst counter dcnt=0 and stats counters=0.
- Reset values of outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
- IDLE:
  - No RAM strobes; both waits are 1.
  - Next state is SERVE_D if dREN|dWEN, else SERVE_I if iREN, else IDLE.
  - Grant latency is one cycle.
- SERVE_D:
  - Outputs: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - dwait=0 only in a cycle with ramstate==ACCESS. That cycle, dload=ramload (combinational) and dcnt increments, saturating at DBURST_MAX.
  - iwait=1 throughout.
- SERVE_I:
  - Outputs: ramREN=iREN, ramWEN=0, ramaddr=iaddr.
  - iwait=0 only when ramstate==ACCESS; iload=ramload that cycle.
  - dwait=1 throughout. A completion clears dcnt to 0.
- When the granted requester's request is 0, the arbiter returns to IDLE next cycle with no RAM strobe. A dropped request is an abandoned access.
- Transitions on completion (ACCESS):
  - From SERVE_D: if iREN and dcnt+1>=DBURST_MAX, go to SERVE_I. Else if dREN|dWEN, stay in SERVE_D (the back-to-back block word needs no idle gap). Else if iREN, go to SERVE_I. Else go to IDLE.
  - From SERVE_I: if dREN|dWEN, go to SERVE_D. Else if iREN, stay in SERVE_I. Else go to IDLE.
- No completion (FREE or BUSY): hold the state and keep outputs stable.
- ERROR: treated as not complete. Wait stays 1 and the same request is re-presented next cycle (retry).
- dREN and dWEN both high: write wins (ramREN=0, ramWEN=1). This is illegal but defined.
- iload and dload are 0 when not completing.
- RST asserted mid-access: strobes drop to 0 in the next cycle. Any in-flight access is discarded; a requester that still asserts is re-arbitrated from IDLE.
- dcnt is 2 bits wide and saturates. It is cleared on entry to SERVE_I and on entry to IDLE.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs dxfer_cnt[31:0] and ixfer_cnt[31:0]. Each increments by 1 on every completed transaction of its requester, wraps modulo 2^32, and is cleared by RST. Also adds stall_cnt[31:0], which increments each cycle the icache waits while in SERVE_D.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- dREN=1 daddr=0x40 with RAM returning ACCESS on the 2nd cycle → ramREN=1 ramaddr=0x40; dwait=0 and dload=ramload=0xDEADBEEF in the ACCESS cycle; iwait stays 1.
- iREN and dREN asserted together from IDLE → SERVE_D is entered first; icache is granted only after the dcache request drops.
- DBURST_MAX=2, dcache issues 3 back-to-back words at 0x80/0x84/0x88 with iREN held high → 0x80 and 0x84 complete, then the icache word, then 0x88.
- ramstate=ERROR for 2 cycles then ACCESS during a dcache write 0x100←0x12345678 → ramWEN held with stable address/data across all cycles; dwait=0 only in the ACCESS cycle.
- RST pulsed for 1 cycle during SERVE_I while ramstate=BUSY → next cycle ramREN=0, state IDLE, iwait=1; with iREN still high, access restarts 2 cycles later.
- MEM_ARB_STATS_EN defined, 3 dcache and 2 icache completions → dxfer_cnt=3, ixfer_cnt=2; after RST both read 0.
